fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 16-bit WISC pipeline. Holds the PC and issues single-outstanding requests to instruction memory with variable latency. Delivers each instruction with its PC+2 to the decode stage (opcode/control decode) through a valid/ready handshake. Handles redirects from execute, stops on a decoded halt, and squashes in-flight wrong-path fetches.

## Interface
- `PC_WIDTH`, 16, PC and instruction-address width.
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `imem_req`  out  1  fetch request; level, held until `imem_valid`.
- `imem_addr`  out  PC_WIDTH  fetch address; stable while `imem_req` is high.
- `imem_valid`  in  1  response strobe; may arrive the same cycle as `imem_req`.
- `imem_rdata`  in  16  instruction word, qualified by `imem_valid`.
- `redirect`  in  1  taken branch/jump/jumpreg/exception from execute.
- `redirect_pc`  in  PC_WIDTH  new PC, qualified by `redirect`.
- `halt_in`  in  1  one-cycle pulse when decode accepts a halt opcode (5'b00000).
- `id_ready`  in  1  decode can accept an instruction this cycle.
- `if_valid`  out  1  `if_instr`/`if_pc_next` are valid.
- `if_instr`  out  16  instruction to decode.
- `if_pc_next`  out  PC_WIDTH  address of the instruction plus 2, used for link and branch base.
- `halted`  out  1  fetch stopped; remains set until reset.

## Operation
- States: FETCH, WAIT, DROP, HALT.
  - FETCH: `imem_req`=1, `imem_addr`=pc.
  - WAIT: response captured in skid, output full, `imem_req`=0.
  - DROP: `imem_req`=1 on old address; the response is discarded.
  - HALT: `imem_req`=0, `halted`=1.
- Output slot is free when `!if_valid || id_ready`.
- FETCH with `imem_valid`:
  - Slot free: load output with {rdata, pc+2}; pc <= pc+2; stay in FETCH.
  - Slot not free: load skid with {rdata, pc+2}; pc <= pc+2; go to WAIT.
- WAIT: when `id_ready`, move skid to output and go to FETCH.
- FETCH without `imem_valid`: hold. Output drains normally.
- Redirect has top priority in every state except HALT.
  - Clears `if_valid` and skid in the same edge.
  - If no request is outstanding, or `imem_valid` arrives this cycle: pc <= redirect_pc, go to FETCH.
  - Otherwise: target <= redirect_pc, go to DROP.
- DROP: on `imem_valid`, pc <= target and go to FETCH (or HALT if a halt is pending). A later redirect in DROP overwrites target.
- `halt_in` without `redirect`:
  - Flush output and skid.
  - If a request is outstanding and `imem_valid` is not present, go to DROP with halt pending; otherwise go to HALT.
- `halt_in` with `redirect`: `halt_in` is ignored.
- HALT ignores `redirect`, `halt_in` and `imem_valid`; only reset exits it.
- PC arithmetic is modulo 2^PC_WIDTH: 16'hFFFE + 2 = 16'h0000. `redirect_pc` is used unmodified.

## Timing
- Reset values:
  - State FETCH, pc=RESET_PC.
  - `if_valid`=0, `if_instr`=0, `if_pc_next`=0, `halted`=0.
  - `imem_req` rises after reset deasserts, with `imem_addr`=RESET_PC.
- Latency: `imem_valid` at cycle N gives `if_valid` at N+1.
- Throughput: one instruction per cycle with zero-wait memory and `id_ready`=1.
- `if_instr`/`if_pc_next` are stable while `if_valid && !id_ready`.
- Redirect at cycle N: `if_valid`=0 at N+1. The first request to redirect_pc is at N+1, or after the drained response.
- Reset mid-operation clears all state immediately. Instruction memory shares `rst_n`, so no stale response follows reset.

## Structure
- Package `fetch_pkg` holds:
  - State enum.
  - `INSTR_W`=16.
  - `PC_INC`=2.
  - `HALT_OPC`=5'b00000.
- Sub-module `fetch_skid_buf`: single-entry {instr, pc_next} buffer with load/unload and flush.

## Test plan
- Zero-wait memory, `id_ready`=1, imem returns 16'h4101, 16'h4202, 16'h4303 → `if_instr` matches in order on consecutive cycles; `if_pc_next`=0002, 0004, 0006.
- `id_ready` low for 3 cycles while a response arrives → output held, skid loaded, `imem_req`=0; the instruction after the held one is delivered the cycle after `id_ready` rises, with no loss or duplication.
- Redirect to 16'h0040 while a 3-cycle-latency fetch of 16'h0008 is outstanding → DROP; the response is discarded; the next `imem_addr`=0040; `if_valid` stays 0 until the 0040 word arrives.
- `halt_in` pulse with `if_valid`=1 → output flushed, `halted`=1, `imem_req`=0 forever; a later `redirect` is ignored.
- pc=16'hFFFE fetch → `if_pc_next`=16'h0000 and the next `imem_addr`=16'h0000.
- `rst_n` asserted during DROP → all outputs return to reset values asynchronously; the first request after release is at `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the WISC instruction-fetch stage.
// No logic: state encoding, widths and the fetch increment.
// Imported by fetch_stage and fetch_skid_buf.
package fetch_pkg;

    // Fetch controller states.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request pc, deliver responses
        ST_WAIT  = 2'd1,  // response parked in skid, output full
        ST_DROP  = 2'd2,  // draining a wrong-path response
        ST_HALT  = 2'd3   // stopped until reset
    } fetch_state_t;

    localparam int         INSTR_W  = 16;
    localparam int         PC_INC   = 2;
    localparam logic [4:0] HALT_OPC = 5'b00000;

    // Decode uses this to recognise the halt opcode in the top five bits.
    function automatic logic is_halt_opc(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 5] == HALT_OPC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry {instr, pc_next} holding buffer for a response decode cannot take.
// Latency: one edge from load to full; contents visible combinationally.
// Backpressure: owner loads only when empty; flush wins over load and unload.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                unload,
    input  logic                flush,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [PC_WIDTH-1:0] in_pc_next,
    output logic                full,
    output logic [INSTR_W-1:0]  instr,
    output logic [PC_WIDTH-1:0] pc_next
);

    // Occupancy and payload; a flush empties the entry regardless of load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 1'b0;
            instr   <= '0;
            pc_next <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (load) begin
            full    <= 1'b1;
            instr   <= in_instr;
            pc_next <= in_pc_next;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: holds pc, single-outstanding imem requests, redirect/halt/squash.
// Latency: imem_valid in cycle N presents if_valid in cycle N+1.
// Backpressure: id_ready low parks one response in the skid and drops imem_req.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                halt_in,
    input  logic                id_ready,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [PC_WIDTH-1:0] if_pc_next,
    output logic                halted
);

    fetch_state_t        state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt;
    logic [PC_WIDTH-1:0] target, target_nxt;
    logic                halt_pend, halt_pend_nxt;
    logic                live;

    logic                out_vld, out_vld_nxt;
    logic [INSTR_W-1:0]  out_instr, out_instr_nxt;
    logic [PC_WIDTH-1:0] out_pc_next, out_pc_next_nxt;

    logic                skid_load, skid_unload, skid_flush, skid_full;
    logic [INSTR_W-1:0]  skid_instr;
    logic [PC_WIDTH-1:0] skid_pc_next;

    logic                req_int;
    logic                slot_free;
    logic [PC_WIDTH-1:0] pc_inc;

    // live holds the request off for the first cycle after reset release,
    // so imem_req only rises once the stage is out of reset.
    assign req_int   = live && ((state == ST_FETCH) || (state == ST_DROP));
    assign slot_free = !out_vld || id_ready;
    assign pc_inc    = pc + PC_WIDTH'(PC_INC);

    fetch_skid_buf #(
        .PC_WIDTH (PC_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .unload     (skid_unload),
        .flush      (skid_flush),
        .in_instr   (imem_rdata),
        .in_pc_next (pc_inc),
        .full       (skid_full),
        .instr      (skid_instr),
        .pc_next    (skid_pc_next)
    );

    // State, pc and output-slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            target      <= RESET_PC;
            halt_pend   <= 1'b0;
            live        <= 1'b0;
            out_vld     <= 1'b0;
            out_instr   <= '0;
            out_pc_next <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            target      <= target_nxt;
            halt_pend   <= halt_pend_nxt;
            live        <= 1'b1;
            out_vld     <= out_vld_nxt;
            out_instr   <= out_instr_nxt;
            out_pc_next <= out_pc_next_nxt;
        end
    end

    // Next-state: redirect beats halt beats normal flow; HALT is terminal.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        target_nxt      = target;
        halt_pend_nxt   = halt_pend;
        out_vld_nxt     = out_vld;
        out_instr_nxt   = out_instr;
        out_pc_next_nxt = out_pc_next;
        skid_load       = 1'b0;
        skid_unload     = 1'b0;
        skid_flush      = 1'b0;

        if (state != ST_HALT) begin
            if (redirect) begin
                out_vld_nxt = 1'b0;
                skid_flush  = 1'b1;
                if (req_int && !imem_valid) begin
                    // Wrong-path response still owed: remember where to go.
                    target_nxt = redirect_pc;
                    state_nxt  = ST_DROP;
                end else if (halt_pend) begin
                    // An accepted halt is sticky; the drained response ends fetch.
                    state_nxt = ST_HALT;
                end else begin
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_FETCH;
                end
            end else if (halt_in) begin
                out_vld_nxt = 1'b0;
                skid_flush  = 1'b1;
                if (req_int && !imem_valid) begin
                    halt_pend_nxt = 1'b1;
                    state_nxt     = ST_DROP;
                end else begin
                    state_nxt = ST_HALT;
                end
            end else begin
                if (out_vld && id_ready) begin
                    out_vld_nxt = 1'b0;
                end
                case (state)
                    ST_FETCH: begin
                        if (req_int && imem_valid) begin
                            pc_nxt = pc_inc;
                            if (slot_free) begin
                                out_vld_nxt     = 1'b1;
                                out_instr_nxt   = imem_rdata;
                                out_pc_next_nxt = pc_inc;
                            end else begin
                                skid_load = 1'b1;
                                state_nxt = ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (id_ready && skid_full) begin
                            out_vld_nxt     = 1'b1;
                            out_instr_nxt   = skid_instr;
                            out_pc_next_nxt = skid_pc_next;
                            skid_unload     = 1'b1;
                            state_nxt       = ST_FETCH;
                        end
                    end
                    ST_DROP: begin
                        if (imem_valid) begin
                            if (halt_pend) begin
                                state_nxt = ST_HALT;
                            end else begin
                                pc_nxt    = target;
                                state_nxt = ST_FETCH;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign imem_req   = req_int;
    assign imem_addr  = pc;
    assign if_valid   = out_vld;
    assign if_instr   = out_instr;
    assign if_pc_next = out_pc_next;
    assign halted     = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a
// program-order scoreboard and a variable-latency instruction memory model.
// Inputs change on the falling edge; outputs are sampled 1ns after it.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt_in;
    logic        id_ready;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc_next;
    logic        halted;

    int passed = 0;
    int total  = 0;
    int lat_fixed = 0;
    bit lat_rand  = 1'b0;
    int rsp_cnt   = 0;

    fetch_stage #(
        .PC_WIDTH (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_in     (halt_in),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc_next  (if_pc_next),
        .halted      (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: 0000->4101, 0002->4202, 0004->4303, ...
    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [7:0] k;
        k = a[8:1];
        return {8'h41 + k, 8'h01 + k} ^ {a[15:8], 8'h00};
    endfunction

    function automatic int pick_lat();
        return lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
    endfunction

    // Instruction memory: answers a held request after rsp_cnt waiting cycles.
    initial begin
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                imem_valid = 1'b0;
                rsp_cnt    = pick_lat();
            end else if (imem_req) begin
                if (rsp_cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = word_at(imem_addr);
                    rsp_cnt    = pick_lat();
                end else begin
                    imem_valid = 1'b0;
                    rsp_cnt    = rsp_cnt - 1;
                end
            end else begin
                imem_valid = 1'b0;
            end
        end
    end

    // Reset with the given memory latency; returns on the releasing falling edge.
    task automatic start(input int lat, input bit rnd);
        lat_fixed   = lat;
        lat_rand    = rnd;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt_in     = 1'b0;
        id_ready    = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        lat_fixed = 0;
        lat_rand  = 1'b0;
        rst_n     = 1'b0;
        redirect  = 1'b0;
        halt_in   = 1'b0;
        id_ready  = 1'b1;
        redirect_pc = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({if_valid, if_instr, if_pc_next, halted} !== 34'h0)
            $display("FAIL reset_outputs: got v=%b i=%h p=%h h=%b want all zero",
                     if_valid, if_instr, if_pc_next, halted);
        else passed++;
        total++;
        if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000})
            $display("FAIL reset_first_req: got req=%b addr=%h want 1/0000", imem_req, imem_addr);
        else passed++;
    endtask

    task automatic test_stream();
        start(0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if ({if_valid, if_instr, if_pc_next} !==
                {1'b1, 16'h4101 + 16'(i * 16'h0101), 16'(2 * (i + 1))})
                $display("FAIL stream_%0d: got v=%b i=%h p=%h want 1/%h/%h", i, if_valid,
                         if_instr, if_pc_next, 16'h4101 + 16'(i * 16'h0101), 16'(2 * (i + 1)));
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        start(0, 1'b0);
        @(negedge clk);
        @(negedge clk); #1;
        total++;
        if ({if_valid, if_instr} !== {1'b1, 16'h4101})
            $display("FAIL bp_first: got v=%b i=%h want 1/4101", if_valid, if_instr);
        else passed++;
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if ({if_valid, if_instr, if_pc_next} !== {1'b1, 16'h4101, 16'h0002})
                $display("FAIL bp_hold_%0d: got v=%b i=%h p=%h want 1/4101/0002",
                         i, if_valid, if_instr, if_pc_next);
            else passed++;
            total++;
            if (imem_req !== 1'b0) $display("FAIL bp_req_%0d: got %b want 0", i, imem_req);
            else passed++;
        end
        id_ready = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({if_valid, if_instr, if_pc_next} !== {1'b1, 16'h4202, 16'h0004})
            $display("FAIL bp_skid_out: got v=%b i=%h p=%h want 1/4202/0004",
                     if_valid, if_instr, if_pc_next);
        else passed++;
        @(negedge clk); #1;
        total++;
        if ({if_valid, if_instr, if_pc_next} !== {1'b1, 16'h4303, 16'h0006})
            $display("FAIL bp_after: got v=%b i=%h p=%h want 1/4303/0006",
                     if_valid, if_instr, if_pc_next);
        else passed++;
    endtask

    task automatic test_redirect_drop();
        logic [15:0] first_new;
        bit          seen_new;
        bit          got;
        start(3, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 16'h0008;
        @(negedge clk); #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0008})
            $display("FAIL rd_req8: got req=%b addr=%h want 1/0008", imem_req, imem_addr);
        else passed++;
        redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 16'h0008, 1'b0})
            $display("FAIL rd_drop: got req=%b addr=%h v=%b want 1/0008/0", imem_req, imem_addr, if_valid);
        else passed++;
        seen_new  = 1'b0;
        first_new = 16'h0000;
        got       = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (if_valid) begin
                got = 1'b1;
                break;
            end
            if (imem_req && imem_addr != 16'h0008 && !seen_new) begin
                seen_new  = 1'b1;
                first_new = imem_addr;
            end
        end
        total++;
        if (!got) $display("FAIL rd_timeout: got no if_valid want one within 30 cycles");
        else passed++;
        total++;
        if ({seen_new, first_new} !== {1'b1, 16'h0040})
            $display("FAIL rd_next_addr: got seen=%b addr=%h want 1/0040", seen_new, first_new);
        else passed++;
        total++;
        if ({if_instr, if_pc_next} !== {word_at(16'h0040), 16'h0042})
            $display("FAIL rd_data: got i=%h p=%h want %h/0042", if_instr, if_pc_next, word_at(16'h0040));
        else passed++;
    endtask

    task automatic test_halt();
        int bad;
        bit got;
        start(0, 1'b0);
        @(negedge clk);
        @(negedge clk); #1;
        total++;
        if (if_valid !== 1'b1) $display("FAIL halt_pre_valid: got %b want 1", if_valid);
        else passed++;
        halt_in = 1'b1;
        @(negedge clk);
        halt_in = 1'b0;
        #1;
        total++;
        if ({if_valid, halted, imem_req} !== 3'b010)
            $display("FAIL halt_now: got v=%b h=%b req=%b want 0/1/0", if_valid, halted, imem_req);
        else passed++;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clk);
        redirect = 1'b0;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (!halted || imem_req || if_valid) bad++;
            @(negedge clk);
        end
        total++;
        if (bad !== 0) $display("FAIL halt_sticky: got %0d bad cycles want 0", bad);
        else passed++;
        // Halt while a fetch is outstanding: drains, then stops.
        start(2, 1'b0);
        @(negedge clk);
        halt_in = 1'b1;
        @(negedge clk);
        halt_in = 1'b0;
        #1;
        total++;
        if ({halted, imem_req, if_valid} !== 3'b010)
            $display("FAIL halt_drain: got h=%b req=%b v=%b want 0/1/0", halted, imem_req, if_valid);
        else passed++;
        got = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (if_valid) bad++;
            if (halted) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if ({got, imem_req, bad != 0} !== 3'b100)
            $display("FAIL halt_drained: got h=%b req=%b badv=%0d want 1/0/0", got, imem_req, bad);
        else passed++;
    endtask

    task automatic test_wrap();
        start(0, 1'b0);
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk); #1;
        total++;
        if ({if_valid, if_instr, if_pc_next} !== {1'b1, word_at(16'hFFFE), 16'h0000})
            $display("FAIL wrap_out: got v=%b i=%h p=%h want 1/%h/0000",
                     if_valid, if_instr, if_pc_next, word_at(16'hFFFE));
        else passed++;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000})
            $display("FAIL wrap_addr: got req=%b addr=%h want 1/0000", imem_req, imem_addr);
        else passed++;
        @(negedge clk); #1;
        total++;
        if ({if_instr, if_pc_next} !== {16'h4101, 16'h0002})
            $display("FAIL wrap_next: got i=%h p=%h want 4101/0002", if_instr, if_pc_next);
        else passed++;
    endtask

    task automatic test_reset_drop();
        bit got;
        start(5, 1'b0);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (if_valid) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if ({got, if_instr} !== {1'b1, 16'h4101})
            $display("FAIL rst_pre: got v=%b i=%h want 1/4101", got, if_instr);
        else passed++;
        redirect    = 1'b1;
        redirect_pc = 16'h0080;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        total++;
        if ({imem_req, imem_addr, if_valid} !== {1'b1, 16'h0002, 1'b0})
            $display("FAIL rst_drop: got req=%b addr=%h v=%b want 1/0002/0", imem_req, imem_addr, if_valid);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({if_valid, if_instr, if_pc_next, halted, imem_req} !== 35'h0)
            $display("FAIL rst_async: got v=%b i=%h p=%h h=%b req=%b want all zero",
                     if_valid, if_instr, if_pc_next, halted, imem_req);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000})
            $display("FAIL rst_restart: got req=%b addr=%h want 1/0000", imem_req, imem_addr);
        else passed++;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (if_valid) begin
                got = 1'b1;
                break;
            end
        end
        total++;
        if ({got, if_instr, if_pc_next} !== {1'b1, 16'h4101, 16'h0002})
            $display("FAIL rst_first: got v=%b i=%h p=%h want 1/4101/0002", got, if_instr, if_pc_next);
        else passed++;
    endtask

    // Random ready/redirect traffic; the scoreboard expects program order:
    // sequential pcs, restarting at redirect_pc after each redirect.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] prev_instr, prev_pcn, prev_addr;
        bit          have_prev, prev_hold, prev_pend;
        int          delivered, bad;
        bit          got;
        for (int ep = 0; ep < 3; ep++) begin
            start(0, 1'b1);
            exp_pc    = 16'h0000;
            have_prev = 1'b0;
            delivered = 0;
            prev_instr = 16'h0; prev_pcn = 16'h0; prev_addr = 16'h0;
            prev_hold = 1'b0; prev_pend = 1'b0;
            for (int c = 0; c < 250; c++) begin
                @(negedge clk);
                id_ready    = ($urandom_range(0, 9) < 7);
                redirect    = ($urandom_range(0, 15) == 0);
                redirect_pc = 16'($urandom);
                #1;
                if (have_prev && prev_hold) begin
                    total++;
                    if ({if_valid, if_instr, if_pc_next} !== {1'b1, prev_instr, prev_pcn})
                        $display("FAIL rnd_hold ep%0d c%0d: got v=%b i=%h p=%h want 1/%h/%h",
                                 ep, c, if_valid, if_instr, if_pc_next, prev_instr, prev_pcn);
                    else passed++;
                end
                if (have_prev && prev_pend) begin
                    total++;
                    if ({imem_req, imem_addr} !== {1'b1, prev_addr})
                        $display("FAIL rnd_addr ep%0d c%0d: got req=%b addr=%h want 1/%h",
                                 ep, c, imem_req, imem_addr, prev_addr);
                    else passed++;
                end
                if (if_valid && id_ready) begin
                    total++;
                    if ({if_instr, if_pc_next} !== {word_at(exp_pc), 16'(exp_pc + 16'd2)})
                        $display("FAIL rnd_deliver ep%0d c%0d: got i=%h p=%h want %h/%h",
                                 ep, c, if_instr, if_pc_next, word_at(exp_pc), 16'(exp_pc + 16'd2));
                    else passed++;
                    exp_pc = exp_pc + 16'd2;
                    delivered++;
                end
                if (redirect) exp_pc = redirect_pc;
                have_prev  = 1'b1;
                prev_hold  = if_valid && !id_ready && !redirect;
                prev_pend  = imem_req && !imem_valid;
                prev_instr = if_instr;
                prev_pcn   = if_pc_next;
                prev_addr  = imem_addr;
            end
            total++;
            if (delivered < 40)
                $display("FAIL rnd_progress ep%0d: got %0d deliveries want >= 40", ep, delivered);
            else passed++;
            @(negedge clk);
            redirect = 1'b0;
            id_ready = 1'b1;
            halt_in  = 1'b1;
            @(negedge clk);
            halt_in = 1'b0;
            got = 1'b0;
            bad = 0;
            for (int c = 0; c < 12; c++) begin
                #1;
                if (if_valid) bad++;
                if (halted) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            total++;
            if ({got, bad != 0} !== 2'b10)
                $display("FAIL rnd_halt ep%0d: got h=%b badv=%0d want 1/0", ep, got, bad);
            else passed++;
            @(negedge clk);
            redirect    = 1'b1;
            redirect_pc = 16'h0200;
            @(negedge clk);
            redirect = 1'b0;
            @(negedge clk); #1;
            total++;
            if ({halted, imem_req, if_valid} !== 3'b100)
                $display("FAIL rnd_halt_redirect ep%0d: got h=%b req=%b v=%b want 1/0/0",
                         ep, halted, imem_req, if_valid);
            else passed++;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt_in     = 1'b0;
        id_ready    = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_halt();
        test_wrap();
        test_reset_drop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
